// File: rtl/zz_pkg.sv
// -----------------------------------------------------------------------------
// zz_pkg : shared types and constants for the zigzag run-length encoder slice.
//   state_e : encoder scan states
//   BLK_SZ  : coefficients per 8x8 block
//   ZRL_RUN : run value carried by a ZRL symbol (stands for 16 zeros)
//   ZZ_N    : default coefficient width; sym_t.level is ZZ_N+1 bits wide, so
//             a different width is selected by changing ZZ_N here
//   sym_t   : one (run, level) output symbol with EOB/last flags
// -----------------------------------------------------------------------------
package zz_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DC   = 2'd1,
    AC   = 2'd2,
    EOB  = 2'd3
  } state_e;

  localparam int BLK_SZ  = 64;
  localparam int ZRL_RUN = 15;
  localparam int ZZ_N    = 8;

  typedef struct packed {
    logic [3:0]             run;
    logic signed [ZZ_N:0]   level;
    logic                   eob;
    logic                   last;
  } sym_t;

endpackage

// File: rtl/zz_rle_encoder_if.sv
// -----------------------------------------------------------------------------
// zz_rle_encoder_if : block-in / symbol-out handshake bundle of zz_rle_encoder.
//   in_valid/in_ready/in_blk : one zigzag-ordered 8x8 block per handshake,
//                              in_blk[r][c] is zigzag position k = 8*r + c
//   out_valid/out_ready      : symbol handshake towards the entropy coder
//   out_run/out_level        : zero run (0..15) and signed level (N+1 bits)
//   out_eob/out_last         : symbol is EOB / final symbol of the block
// Modports: slave = encoder side, master = block producer + symbol consumer.
// -----------------------------------------------------------------------------
interface zz_rle_encoder_if #(
  parameter int N = 8
);

  logic                     in_valid;
  logic                     in_ready;
  logic [7:0][7:0][N-1:0]   in_blk;
  logic                     out_valid;
  logic                     out_ready;
  logic [3:0]               out_run;
  logic signed [N:0]        out_level;
  logic                     out_eob;
  logic                     out_last;

  modport slave (
    input  in_valid, in_blk, out_ready,
    output in_ready, out_valid, out_run, out_level, out_eob, out_last
  );

  modport master (
    output in_valid, in_blk, out_ready,
    input  in_ready, out_valid, out_run, out_level, out_eob, out_last
  );

endinterface

// File: rtl/zz_last_nz.sv
// -----------------------------------------------------------------------------
// zz_last_nz : combinational priority encoder over the 63 AC coefficients.
//   ac      : coefficients at zigzag positions 1..63
//   last_nz : highest k in 1..63 whose coefficient is nonzero, 0 if none
// -----------------------------------------------------------------------------
module zz_last_nz
  import zz_pkg::*;
#(
  parameter int N = ZZ_N
) (
  input  logic [BLK_SZ-1:1][N-1:0] ac,
  output logic [5:0]               last_nz
);

  // Ascending scan: the last hit wins, giving the highest nonzero index.
  always_comb begin
    last_nz = '0;
    for (int k = 1; k < BLK_SZ; k++) begin
      if (ac[k] != '0) last_nz = 6'(k);
    end
  end

endmodule

// File: rtl/zz_rle_encoder.sv
// -----------------------------------------------------------------------------
// zz_rle_encoder : latches one zigzag-ordered 8x8 block and streams JPEG-style
// (run, level) symbols: DC, AC, ZRL (16 zeros) and EOB.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : zz_rle_encoder_if.slave (block input, symbol output handshakes)
//   busy  : encoder is not IDLE
// Build option: define RLE_DC_DIFF_EN to emit the DC symbol as the difference
// from the previously accepted block DC; otherwise the DC level is coef[0].
// -----------------------------------------------------------------------------
module zz_rle_encoder
  import zz_pkg::*;
#(
  parameter int N = ZZ_N
) (
  input  logic               clk,
  input  logic               rst_n,
  zz_rle_encoder_if.slave    bus,
  output logic               busy
);

  localparam logic [3:0] ZRL_R  = 4'(ZRL_RUN);
  localparam logic [5:0] LAST_K = 6'(BLK_SZ - 1);

  function automatic logic signed [N:0] sext(input logic signed [N-1:0] v);
    return {v[N-1], v};
  endfunction

  state_e                    state_q, state_d;
  logic [5:0]                idx_q, idx_d;
  logic [5:0]                last_nz_q, last_nz_d, lnz;
  logic [3:0]                run_q, run_d;
  logic [BLK_SZ-1:0][N-1:0]  blk_flat, coef_q;
  logic                      load, emit, slot_free, vld_q;
  sym_t                      sym_d, sym_q;
  logic signed [N-1:0]       cur;
  logic signed [N:0]         dc_level;

  // in_blk[r][c] packs into the same bit positions as a flat index k = 8r + c.
  assign blk_flat  = bus.in_blk;
  assign slot_free = !vld_q || bus.out_ready;
  assign cur       = coef_q[idx_q];

  zz_last_nz #(.N(N)) u_last_nz (
    .ac      (blk_flat[BLK_SZ-1:1]),
    .last_nz (lnz)
  );

`ifdef RLE_DC_DIFF_EN
  logic signed [N-1:0] prev_dc_q;
  logic                dc_pend_q;

  assign dc_level = sext(coef_q[0]) - sext(prev_dc_q);

  // prev_dc follows the DC actually accepted downstream. The buffer cannot be
  // reloaded while a DC symbol is pending, so coef_q[0] is still that DC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_dc_q <= '0;
      dc_pend_q <= 1'b0;
    end else begin
      if (vld_q && bus.out_ready && dc_pend_q) prev_dc_q <= coef_q[0];
      if (slot_free) dc_pend_q <= emit && (state_q == DC);
    end
  end
`else
  assign dc_level = sext(coef_q[0]);
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    run_d     = run_q;
    last_nz_d = last_nz_q;
    load      = 1'b0;
    emit      = 1'b0;
    sym_d     = '0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          load      = 1'b1;
          last_nz_d = lnz;
          idx_d     = '0;
          run_d     = '0;
          state_d   = DC;
        end
      end
      DC: begin
        if (slot_free) begin
          emit        = 1'b1;
          sym_d.level = dc_level;
          idx_d       = 6'd1;
          run_d       = '0;
          state_d     = (last_nz_q == '0) ? EOB : AC;
        end
      end
      AC: begin
        if (slot_free) begin
          if (cur == '0) begin
            // A zero arriving at run 15 completes a group of 16 -> ZRL.
            idx_d = idx_q + 6'd1;
            if (run_q == ZRL_R) begin
              emit      = 1'b1;
              sym_d.run = ZRL_R;
              run_d     = '0;
            end else begin
              run_d = run_q + 4'd1;
            end
          end else begin
            emit        = 1'b1;
            sym_d.run   = run_q;
            sym_d.level = sext(cur);
            run_d       = '0;
            if (idx_q == last_nz_q) begin
              // A nonzero at position 63 ends the block without an EOB.
              if (last_nz_q == LAST_K) begin
                sym_d.last = 1'b1;
                state_d    = IDLE;
              end else begin
                state_d = EOB;
              end
            end else begin
              idx_d = idx_q + 6'd1;
            end
          end
        end
      end
      EOB: begin
        if (slot_free) begin
          emit       = 1'b1;
          sym_d.eob  = 1'b1;
          sym_d.last = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output slot; the slot only changes when it is free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      run_q     <= '0;
      last_nz_q <= '0;
      vld_q     <= 1'b0;
      sym_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      run_q     <= run_d;
      last_nz_q <= last_nz_d;
      if (slot_free) begin
        vld_q <= emit;
        if (emit) sym_q <= sym_d;
      end
    end
  end

  // Coefficient buffer: data only, written on the load handshake.
  always_ff @(posedge clk) begin
    if (load) coef_q <= blk_flat;
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = vld_q;
  assign bus.out_run   = sym_q.run;
  assign bus.out_level = sym_q.level;
  assign bus.out_eob   = sym_q.eob;
  assign bus.out_last  = sym_q.last;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_zz_rle_encoder.sv
// -----------------------------------------------------------------------------
// tb_zz_rle_encoder : directed blocks against a symbol-list model of the
// run-length rules, with a scoreboard checking every accepted symbol and the
// stability of every stalled symbol.
// -----------------------------------------------------------------------------
module tb_zz_rle_encoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  zz_rle_encoder_if #(.N(8)) bus ();

  zz_rle_encoder #(.N(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .busy  (busy)
  );

  typedef struct {
    int run;
    int level;
    bit eob;
    bit last;
  } exp_t;

  exp_t expq[$];
  exp_t e;
  int   prev_dc = 0;
  int   n_vec   = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input int act, input int want);
    n_vec++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic void push_sym(input int r, input int l, input bit eo, input bit la);
    exp_t s;
    s.run = r; s.level = l; s.eob = eo; s.last = la;
    expq.push_back(s);
  endfunction

  // Symbol list from the block: DC, then for each nonzero AC value the zero
  // gap before it split into ZRLs of 16 plus a remainder run, then EOB unless
  // the block's last nonzero sits at position 63.
  function automatic void model_push(input logic [63:0][7:0] b);
    int v[64];
    int lnz, z, dcl;
    for (int k = 0; k < 64; k++) v[k] = int'($signed(b[k]));
`ifdef RLE_DC_DIFF_EN
    dcl = v[0] - prev_dc;
`else
    dcl = v[0];
`endif
    prev_dc = v[0];
    lnz = 0;
    for (int k = 1; k < 64; k++) if (v[k] != 0) lnz = k;
    push_sym(0, dcl, 1'b0, 1'b0);
    z = 0;
    for (int k = 1; k <= lnz; k++) begin
      if (v[k] == 0) z++;
      else begin
        while (z >= 16) begin
          push_sym(15, 0, 1'b0, 1'b0);
          z -= 16;
        end
        push_sym(z, v[k], 1'b0, k == 63);
        z = 0;
      end
    end
    if (lnz < 63) push_sym(0, 0, 1'b1, 1'b1);
  endfunction

  // Scoreboard: sampled 1 time unit before each rising edge, after all drives.
  bit        p_hold = 1'b0;
  int        p_pack = 0;
  always @(negedge clk) begin
    #4;
    if (!rst_n) begin
      p_hold = 1'b0;
    end else begin
      if (p_hold)
        chk("stall_stable", {bus.out_valid, bus.out_eob, bus.out_last, bus.out_run, bus.out_level}, p_pack);
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_symbol: got run=%0d level=%0d eob=%0d, expected none",
                   bus.out_run, bus.out_level, bus.out_eob);
        end else begin
          e = expq.pop_front();
          chk("sym_run",   int'(bus.out_run),   e.run);
          chk("sym_level", int'(bus.out_level), e.level);
          chk("sym_eob",   int'(bus.out_eob),   int'(e.eob));
          chk("sym_last",  int'(bus.out_last),  int'(e.last));
        end
      end
      p_hold = bus.out_valid && !bus.out_ready;
      p_pack = {bus.out_valid, bus.out_eob, bus.out_last, bus.out_run, bus.out_level};
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic load(input logic [63:0][7:0] b);
    int t = 0;
    while (!bus.in_ready && t < 300) begin
      tick();
      t++;
    end
    if (!bus.in_ready) begin
      chk("load_wait_in_ready", 0, 1);
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_blk   = b;
    model_push(b);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input bit toggle);
    int t = 0;
    while (expq.size() != 0 && t < 600) begin
      if (toggle) bus.out_ready = (t % 3 != 0);
      tick();
      t++;
    end
    bus.out_ready = 1'b1;
    chk("drain_remaining", expq.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [63:0][7:0] b;
  int t;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_blk    = '0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready",  int'(bus.in_ready),  1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_busy",      int'(busy),          0);
    chk("rst_out_run",   int'(bus.out_run),   0);
    chk("rst_out_level", int'(bus.out_level), 0);
    chk("rst_out_eob",   int'(bus.out_eob),   0);
    chk("rst_out_last",  int'(bus.out_last),  0);
    rst_n = 1'b1;
    tick();

    // DC 12, k1 = -3, with first-symbol latency check.
    b = '0; b[0] = 8'd12; b[1] = 8'hFD;
    load(b);
    chk("lat1_out_valid", int'(bus.out_valid), 0);
    chk("lat1_in_ready",  int'(bus.in_ready),  0);
    chk("lat1_busy",      int'(busy),          1);
    chk("model1_size",    expq.size(),         3);
    chk("model1_ac",      expq[1].level,       -3);
    chk("model1_eob",     int'(expq[2].eob),   1);
    tick();
    chk("lat2_out_valid", int'(bus.out_valid), 1);
    chk("lat2_dc_level",  int'(bus.out_level), 12);
    drain(1'b0);
    chk("blk1_idle", int'(busy), 0);

    // DC 5, k20 = 7: ZRL then run 3; DC stalled for 5 cycles.
    b = '0; b[0] = 8'd5; b[20] = 8'd7;
    load(b);
    chk("model2_size",    expq.size(),     4);
    chk("model2_zrl_run", expq[1].run,     15);
    chk("model2_zrl_lvl", expq[1].level,   0);
    chk("model2_run3",    expq[2].run,     3);
    chk("model2_lvl7",    expq[2].level,   7);
    tick();
    bus.out_ready = 1'b0;
    repeat (5) tick();
    chk("stall_dc_valid", int'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    drain(1'b0);
    chk("blk2_idle", int'(busy), 0);

    // All 64 nonzero (1..64): no EOB, last on position 63.
    for (int k = 0; k < 64; k++) b[k] = 8'(k + 1);
    load(b);
    chk("model3_size",   expq.size(),         64);
    chk("model3_lastlv", expq[63].level,      64);
    chk("model3_last",   int'(expq[63].last), 1);
    chk("model3_prelst", int'(expq[62].last), 0);
    drain(1'b1);
    chk("blk3_idle", int'(busy), 0);

    // All-zero block: DC then EOB.
    b = '0;
    load(b);
    chk("model4_size", expq.size(),        2);
    chk("model4_eob",  int'(expq[1].eob),  1);
    drain(1'b0);

    // New block loaded while the previous EOB is stalled.
    b = '0;
    load(b);
    t = 0;
    while (!(bus.out_valid && bus.out_eob) && t < 50) begin
      tick();
      t++;
    end
    bus.out_ready = 1'b0;
    chk("pend_eob_seen",  int'(bus.out_valid && bus.out_eob), 1);
    chk("pend_in_ready",  int'(bus.in_ready), 1);
    b = '0; b[0] = 8'd9; b[3] = 8'h80;
    load(b);
    repeat (3) tick();
    chk("pend_eob_held",  int'(bus.out_eob), 1);
    chk("pend_busy",      int'(busy),        1);
    bus.out_ready = 1'b1;
    drain(1'b0);

    // Reset in the middle of the AC scan.
    for (int k = 0; k < 64; k++) b[k] = 8'(k + 1);
    load(b);
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_in_ready",  int'(bus.in_ready),  1);
    chk("midrst_busy",      int'(busy),          0);
    expq.delete();
    prev_dc = 0;
    rst_n = 1'b1;
    tick();

    // DC 10 then DC 4 from a fresh reset.
    b = '0; b[0] = 8'd10;
    load(b);
    chk("model6a_dc", expq[0].level, 10);
    drain(1'b0);
    b = '0; b[0] = 8'd4;
    load(b);
`ifdef RLE_DC_DIFF_EN
    chk("model6b_dc", expq[0].level, -6);
`else
    chk("model6b_dc", expq[0].level, 4);
`endif
    drain(1'b0);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
